// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and elaboration helpers for the chunked pipelined adder.
//   DEF_WIDTH   : default operand / sum width in bits
//   DEF_CHUNK   : default number of bits added per pipeline stage
//   calc_stages : pipeline depth for a WIDTH/CHUNK pair; returns 0 when the
//                 pair is illegal (WIDTH not a positive multiple of CHUNK)
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   function automatic int calc_stages(input int width, input int chunk);
      if (chunk < 1 || width < chunk || (width % chunk) != 0) begin
         return 0;
      end
      return width / chunk;
   endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_nbit_if
// Operand and result streams of the pipelined adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (s, cout, ovf)
//   master modport      : producer/consumer side (drives operands, out_ready)
//   slave modport       : adder side
//
// Handshake: a transfer happens on every rising clk edge where valid and
// ready are both 1. A producer holding valid=1 keeps its payload stable until
// that edge; ready may depend combinationally on the opposite side's ready.
// Result payload is meaningless while out_valid=0.
// -----------------------------------------------------------------------------
interface pipelined_adder_nbit_if
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );

endinterface

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit adder used for one pipeline stage.
//   x, y  : chunk operands
//   ci    : carry in
//   sum   : CHUNK-bit sum
//   co    : carry out of the chunk
//   c_msb : carry into the chunk's most significant bit
// -----------------------------------------------------------------------------
module chunk_adder
   import adder_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] full;

   assign full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
   assign sum   = full[CHUNK-1:0];
   assign co    = full[CHUNK];
   // The sum bit is x ^ y ^ carry_in, so the carry into the MSB falls out
   // of the MSB sum bit without a second adder.
   assign c_msb = sum[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// pipelined_adder_nbit
// WIDTH-bit adder split into STAGES = WIDTH/CHUNK pipeline stages; stage k adds
// chunk k of the operands plus the carry registered by stage k-1.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, clears every register
//   bus   : operand/result streams (slave side of pipelined_adder_nbit_if)
// The whole pipeline freezes while a result is presented and not taken, so
// in_ready is simply the inverse of that stall condition.
// -----------------------------------------------------------------------------
module pipelined_adder_nbit
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipelined_adder_nbit_if.slave bus
);

   localparam int STAGES = calc_stages(WIDTH, CHUNK);

   if (STAGES < 1) begin : g_bad_params
      $error("pipelined_adder_nbit: WIDTH must be a positive multiple of CHUNK");
   end

   // One pipeline slot. sum holds the chunks already added (upper chunks are
   // zero until their stage fills them); a/b carry the operand set forward so
   // later stages can still reach their chunks.
   typedef struct packed {
      logic             valid;
      logic             carry;
      logic             c_msb;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } stage_t;

   stage_t pipe_q [STAGES];
   stage_t pipe_d [STAGES];
   logic   stall;

   assign stall = pipe_q[STAGES-1].valid && !bus.out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] x_w;
      logic [CHUNK-1:0] y_w;
      logic [CHUNK-1:0] sum_w;
      logic             ci_w;
      logic             co_w;
      logic             cm_w;
      logic             v_w;
      logic [WIDTH-1:0] base_w;
      logic [WIDTH-1:0] a_w;
      logic [WIDTH-1:0] b_w;

      if (k == 0) begin : g_first
         assign v_w    = bus.in_valid;
         assign a_w    = bus.a;
         assign b_w    = bus.b;
         assign ci_w   = bus.cin;
         assign base_w = '0;
      end else begin : g_next
         assign v_w    = pipe_q[k-1].valid;
         assign a_w    = pipe_q[k-1].a;
         assign b_w    = pipe_q[k-1].b;
         assign ci_w   = pipe_q[k-1].carry;
         assign base_w = pipe_q[k-1].sum;
      end

      assign x_w = a_w[k*CHUNK +: CHUNK];
      assign y_w = b_w[k*CHUNK +: CHUNK];

      chunk_adder #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .x     (x_w),
         .y     (y_w),
         .ci    (ci_w),
         .sum   (sum_w),
         .co    (co_w),
         .c_msb (cm_w)
      );

      assign pipe_d[k] = '{
         valid: v_w,
         carry: co_w,
         c_msb: cm_w,
         sum:   base_w | (WIDTH'(sum_w) << (k * CHUNK)),
         a:     a_w,
         b:     b_w
      };
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            pipe_q[k] <= '0;
         end
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
      end
   end

   assign bus.in_ready  = !stall;
   assign bus.out_valid = pipe_q[STAGES-1].valid;
   assign bus.s         = pipe_q[STAGES-1].sum;
   assign bus.cout      = pipe_q[STAGES-1].carry;
   // The last stage holds the top chunk, so its MSB carry is the carry into
   // bit WIDTH-1 of the full addition.
   assign bus.ovf       = pipe_q[STAGES-1].c_msb ^ pipe_q[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder_nbit
// Three adder instances share one stimulus set: 16/4 (four stages), 4/1
// (four one-bit stages, used for the exhaustive sweep) and 8/8 (single
// registered adder). Each test selects which instance it observes.
// Results are packed as {ovf, cout, s zero-extended to 16 bits}.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_nbit;

   logic        clk;
   logic        rst_n;
   logic        drv_valid;
   logic [15:0] drv_a;
   logic [15:0] drv_b;
   logic        drv_cin;
   logic        drv_ready;

   int          n_tests;
   int          n_fail;
   logic [17:0] exp_q[$];

   pipelined_adder_nbit_if #(.WIDTH(16)) bus16 ();
   pipelined_adder_nbit_if #(.WIDTH(4))  bus4 ();
   pipelined_adder_nbit_if #(.WIDTH(8))  bus8 ();

   assign bus16.in_valid  = drv_valid;
   assign bus16.a         = drv_a;
   assign bus16.b         = drv_b;
   assign bus16.cin       = drv_cin;
   assign bus16.out_ready = drv_ready;
   assign bus4.in_valid   = drv_valid;
   assign bus4.a          = drv_a[3:0];
   assign bus4.b          = drv_b[3:0];
   assign bus4.cin        = drv_cin;
   assign bus4.out_ready  = drv_ready;
   assign bus8.in_valid   = drv_valid;
   assign bus8.a          = drv_a[7:0];
   assign bus8.b          = drv_b[7:0];
   assign bus8.cin        = drv_cin;
   assign bus8.out_ready  = drv_ready;

   pipelined_adder_nbit #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   pipelined_adder_nbit #(.WIDTH(4),  .CHUNK(1)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
   pipelined_adder_nbit #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------- reference model
   // Plain integer arithmetic on w-bit operands; signs read as "value >= 2^(w-1)".
   function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
      longint unsigned m, am, bm, t, sm;
      logic            co, ov, sa, sb, ss;
      m  = 64'd1 << w;
      am = a % m;
      bm = b % m;
      t  = am + bm + c;
      sm = t % m;
      co = (t >= m);
      sa = (am >= m / 2);
      sb = (bm >= m / 2);
      ss = (sm >= m / 2);
      ov = (sa == sb) && (ss != sa);
      return {ov, co, 16'(sm)};
   endfunction

   // --------------------------------------------------------------- driver
   // Drives one cycle at the falling edge and samples the selected instance
   // after inputs settle; the transfer decision belongs to the next rising edge.
   task automatic drive(input int sel, input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input logic rdy,
                        output logic ir, output logic ov, output logic [17:0] res);
      @(negedge clk);
      drv_valid = v;
      drv_a     = a;
      drv_b     = b;
      drv_cin   = c;
      drv_ready = rdy;
      #1;
      case (sel)
         4: begin
            ir = bus4.in_ready; ov = bus4.out_valid;
            res = {bus4.ovf, bus4.cout, 12'd0, bus4.s};
         end
         8: begin
            ir = bus8.in_ready; ov = bus8.out_valid;
            res = {bus8.ovf, bus8.cout, 8'd0, bus8.s};
         end
         default: begin
            ir = bus16.in_ready; ov = bus16.out_valid;
            res = {bus16.ovf, bus16.cout, bus16.s};
         end
      endcase
   endtask

   task automatic flush();
      logic ir, ov;
      logic [17:0] res;
      repeat (8) drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, ir, ov, res);
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      n_tests++; if (bus16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16: got %b expected 0", bus16.out_valid); end
      n_tests++; if (bus16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready16: got %b expected 1", bus16.in_ready); end
      n_tests++; if ({bus16.ovf, bus16.cout, bus16.s} !== 18'd0) begin n_fail++; $display("FAIL reset_result16: got %h expected 0", {bus16.ovf, bus16.cout, bus16.s}); end
      n_tests++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4: got %b expected 0", bus4.out_valid); end
      n_tests++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b expected 0", bus8.out_valid); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ripple();
      logic ir, ov, done;
      logic [17:0] res, e;
      flush();
      drive(16, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, ir, ov, res);
      n_tests++; if (ir !== 1'b1) begin n_fail++; $display("FAIL ripple_accept: in_ready %b expected 1", ir); end
      exp_q.push_back(18'h10000);
      done = 1'b0;
      for (int i = 1; i <= 20 && !done; i++) begin
         drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, ir, ov, res);
         if (ov) begin
            done = 1'b1;
            e = exp_q.pop_front();
            n_tests++; if (i != 4) begin n_fail++; $display("FAIL ripple_latency: got %0d edges expected 4", i); end
            n_tests++; if (res !== e) begin n_fail++; $display("FAIL ripple_result: got %h expected %h", res, e); end
         end
      end
      n_tests++; if (!done) begin n_fail++; $display("FAIL ripple_timeout: no result within 20 cycles expected 1"); end
   endtask

   task automatic test_overflow();
      logic ir, ov;
      logic [17:0] res, e;
      logic [15:0] oa [2];
      logic [15:0] ob [2];
      logic [17:0] lit [2];
      int idx, got;
      flush();
      oa[0] = 16'h7FFF; ob[0] = 16'h0001; lit[0] = 18'h28000;
      oa[1] = 16'h8000; ob[1] = 16'h8000; lit[1] = 18'h30000;
      idx = 0; got = 0;
      for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
         drive(16, idx < 2, oa[idx % 2], ob[idx % 2], 1'b0, 1'b1, ir, ov, res);
         if (ov) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++; $display("FAIL overflow_extra: unexpected result %h expected none", res);
            end else begin
               e = exp_q.pop_front();
               n_tests++; if (res !== e) begin n_fail++; $display("FAIL overflow_result%0d: got %h expected %h", got, res, e); end
            end
            got++;
         end
         if (idx < 2 && ir) begin exp_q.push_back(lit[idx]); idx++; end
      end
      n_tests++; if (got != 2) begin n_fail++; $display("FAIL overflow_count: got %0d expected 2", got); end
   endtask

   task automatic test_streaming();
      logic ir, ov, c;
      logic [17:0] res, e;
      logic [15:0] a, b;
      int idx, got;
      flush();
      idx = 0; got = 0;
      for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
         a = 16'(idx);
         b = 16'(idx * 4096);
         c = idx[0];
         drive(16, idx < 8, a, b, c, 1'b1, ir, ov, res);
         if (ov) begin
            n_tests++; if (cyc != 4 + got) begin n_fail++; $display("FAIL stream_timing%0d: got cycle %0d expected %0d", got, cyc, 4 + got); end
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++; $display("FAIL stream_extra: unexpected result %h expected none", res);
            end else begin
               e = exp_q.pop_front();
               n_tests++; if (res !== e) begin n_fail++; $display("FAIL stream_result%0d: got %h expected %h", got, res, e); end
            end
            got++;
         end
         if (idx < 8) begin
            n_tests++; if (ir !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready%0d: got %b expected 1", idx, ir); end
            if (ir) begin exp_q.push_back(model(16, a, b, c)); idx++; end
         end
      end
      n_tests++; if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", got); end
   endtask

   task automatic test_stall();
      logic ir, ov, rdy, v;
      logic [17:0] res, e, held;
      logic [15:0] oa [12];
      logic [15:0] ob [12];
      logic        oc [12];
      int idx, got, k;
      flush();
      for (int i = 0; i < 12; i++) begin
         oa[i] = 16'($urandom); ob[i] = 16'($urandom); oc[i] = 1'($urandom_range(0, 1));
      end
      idx = 0; got = 0; held = '0;
      for (int cyc = 0; cyc < 60 && (idx < 12 || exp_q.size() > 0); cyc++) begin
         rdy = !(cyc >= 6 && cyc < 9);
         v   = (idx < 12);
         k   = v ? idx : 0;
         drive(16, v, oa[k], ob[k], oc[k], rdy, ir, ov, res);
         if (cyc == 6) begin
            held = res;
            n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL stall_full: out_valid %b expected 1", ov); end
         end
         if (cyc >= 6 && cyc < 9) begin
            n_tests++; if (ir !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready%0d: got %b expected 0", cyc, ir); end
            if (cyc > 6) begin
               n_tests++; if (ov !== 1'b1 || res !== held) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%h expected 1/%h", cyc, ov, res, held); end
            end
         end
         if (ov && rdy) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++; $display("FAIL stall_extra: unexpected result %h expected none", res);
            end else begin
               e = exp_q.pop_front();
               n_tests++; if (res !== e) begin n_fail++; $display("FAIL stall_result%0d: got %h expected %h", got, res, e); end
            end
            got++;
         end
         if (v && ir) begin exp_q.push_back(model(16, oa[k], ob[k], oc[k])); idx++; end
      end
      n_tests++; if (got != 12 || exp_q.size() != 0) begin n_fail++; $display("FAIL stall_count: got %0d results expected 12", got); end
   endtask

   task automatic test_random();
      logic ir, ov, rdy, pend, c;
      logic [17:0] res, e;
      logic [15:0] a, b;
      int cyc, got;
      flush();
      pend = 1'b0; a = '0; b = '0; c = 1'b0; got = 0;
      for (cyc = 0; cyc < 400 && (cyc < 300 || pend || exp_q.size() > 0); cyc++) begin
         if (!pend && cyc < 300 && $urandom_range(0, 9) < 7) begin
            pend = 1'b1; a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
         end
         rdy = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 9) < 6);
         drive(16, pend, a, b, c, rdy, ir, ov, res);
         n_tests++; if (ir !== !(ov && !rdy)) begin n_fail++; $display("FAIL random_in_ready%0d: got %b expected %b", cyc, ir, !(ov && !rdy)); end
         if (ov && rdy) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++; $display("FAIL random_extra: unexpected result %h expected none", res);
            end else begin
               e = exp_q.pop_front();
               n_tests++; if (res !== e) begin n_fail++; $display("FAIL random_result%0d: got %h expected %h", got, res, e); end
            end
            got++;
         end
         if (pend && ir) begin exp_q.push_back(model(16, a, b, c)); pend = 1'b0; end
      end
      n_tests++; if (pend || exp_q.size() != 0) begin n_fail++; $display("FAIL random_drain: %0d results outstanding expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_midflight();
      logic ir, ov;
      logic [17:0] res, e;
      logic [15:0] a, b;
      int seen;
      logic done;
      flush();
      for (int i = 0; i < 3; i++) begin
         drive(16, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, ir, ov, res);
         n_tests++; if (ir !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept%0d: got %b expected 1", i, ir); end
      end
      drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, ir, ov, res);
      drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, ir, ov, res);
      n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL rstmid_inflight: out_valid %b expected 1", ov); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus16.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", bus16.out_valid); end
      n_tests++; if (bus16.s !== 16'd0 || bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", {bus16.ovf, bus16.cout, bus16.s}); end
      n_tests++; if (bus16.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", bus16.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, ir, ov, res);
         if (ov) seen++;
      end
      n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_ghost: got %0d stale results expected 0", seen); end
      a = 16'($urandom); b = 16'($urandom);
      drive(16, 1'b1, a, b, 1'b0, 1'b1, ir, ov, res);
      n_tests++; if (ir !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart: in_ready %b expected 1", ir); end
      e = model(16, a, b, 1'b0);
      done = 1'b0;
      for (int i = 1; i <= 20 && !done; i++) begin
         drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, ir, ov, res);
         if (ov) begin
            done = 1'b1;
            n_tests++; if (res !== e) begin n_fail++; $display("FAIL rstmid_after: got %h expected %h", res, e); end
         end
      end
      n_tests++; if (!done) begin n_fail++; $display("FAIL rstmid_timeout: no result within 20 cycles expected 1"); end
   endtask

   task automatic test_exhaustive4();
      logic ir, ov, rdy, v, c;
      logic [17:0] res, e;
      logic [15:0] a, b;
      int idx, got, errs;
      flush();
      idx = 0; got = 0; errs = 0;
      for (int cyc = 0; cyc < 3000 && (idx < 512 || exp_q.size() > 0); cyc++) begin
         v   = (idx < 512);
         a   = 16'(idx & 15);
         b   = 16'((idx >> 4) & 15);
         c   = 1'((idx >> 8) & 1);
         rdy = ($urandom_range(0, 3) != 0);
         drive(4, v, a, b, c, rdy, ir, ov, res);
         if (ov && rdy) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++; $display("FAIL exh4_extra: unexpected result %h expected none", res);
            end else begin
               e = exp_q.pop_front();
               n_tests++; if (res !== e) begin n_fail++; errs++; if (errs <= 10) $display("FAIL exh4_result%0d: got %h expected %h", got, res, e); end
            end
            got++;
         end
         if (v && ir) begin exp_q.push_back(model(4, a, b, c)); idx++; end
      end
      n_tests++; if (got != 512 || exp_q.size() != 0) begin n_fail++; $display("FAIL exh4_count: got %0d results expected 512", got); end
   endtask

   task automatic test_single_stage();
      logic ir, ov, rdy, v, c, done;
      logic [17:0] res, e;
      logic [15:0] a, b;
      int idx, got;
      flush();
      drive(8, 1'b1, 16'h00FF, 16'h0000, 1'b1, 1'b1, ir, ov, res);
      n_tests++; if (ir !== 1'b1) begin n_fail++; $display("FAIL single_accept: in_ready %b expected 1", ir); end
      drive(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, ir, ov, res);
      n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL single_latency: out_valid %b after 1 edge expected 1", ov); end
      n_tests++; if (res !== 18'h10000) begin n_fail++; $display("FAIL single_ripple: got %h expected 10000", res); end
      idx = 0; got = 0; done = 1'b0;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 200 && (idx < 20 || exp_q.size() > 0); cyc++) begin
         v   = (idx < 20);
         rdy = ($urandom_range(0, 1) != 0);
         drive(8, v, a, b, c, rdy, ir, ov, res);
         if (ov && rdy) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++; $display("FAIL single_extra: unexpected result %h expected none", res);
            end else begin
               e = exp_q.pop_front();
               n_tests++; if (res !== e) begin n_fail++; $display("FAIL single_result%0d: got %h expected %h", got, res, e); end
            end
            got++;
         end
         if (v && ir) begin
            exp_q.push_back(model(8, a, b, c)); idx++;
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
         end
      end
      n_tests++; if (got != 20 || exp_q.size() != 0) begin n_fail++; $display("FAIL single_count: got %0d results expected 20", got); end
   endtask

   // ----------------------------------------------------------- sequence
   initial begin
      n_tests   = 0;
      n_fail    = 0;
      drv_valid = 1'b0;
      drv_a     = '0;
      drv_b     = '0;
      drv_cin   = 1'b0;
      drv_ready = 1'b1;
      rst_n     = 1'b1;
      test_reset();
      test_ripple();
      test_overflow();
      test_streaming();
      test_stall();
      test_random();
      test_reset_midflight();
      test_exhaustive4();
      test_single_stage();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_nbit.md
PIPELINED_ADDER_NBIT -- requirements
Module: pipelined_adder_nbit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL derive localparam STAGES = WIDTH/CHUNK, which is also the pipeline depth.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a, b and cin are presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: unsigned or two's-complement addends.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-010 The block SHALL have port out_valid, output, 1 bit: s, cout and ovf hold a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-012 The block SHALL have port s, output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
REQ-013 The block SHALL have port cout, output, 1 bit: bit WIDTH of a+b+cin.
REQ-014 The block SHALL have port ovf, output, 1 bit: signed overflow, i.e. the carry into the MSB XOR cout.

Function
REQ-015 Handshake: a transfer SHALL occur on every rising edge where valid and ready are both 1.
- Input side: in_valid && in_ready.
- Output side: out_valid && out_ready.
REQ-016 Stall: stall = out_valid && !out_ready; in_ready SHALL equal !stall (combinational).
REQ-017 While stall is 1, every pipeline register, including valid bits, SHALL hold its value; s, cout and ovf SHALL remain stable.
REQ-018 While stall is 0, every stage SHALL advance one position per cycle; stage 0 SHALL load in_valid, a, b and cin.
REQ-019 Stage k (k = 0..STAGES-1) SHALL add chunk k of a and b plus the carry from stage k-1; stage 0 SHALL use cin as its carry.
- Stage k SHALL register its CHUNK sum bits and its carry-out.
REQ-020 Sum bits already computed SHALL travel forward with their operand set; operand chunks not yet added SHALL be delayed alongside them.
REQ-021 Latency: with no stall, a result accepted at edge N SHALL appear with out_valid=1 after edge N+STAGES-1.
- Example: STAGES=4 gives a result in the cycle after the 4th edge.
REQ-022 Throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-023 Results SHALL leave in acceptance order; none SHALL be lost, duplicated or reordered across any stall pattern.
REQ-024 Bubbles (in_valid=0) SHALL propagate as stages with valid=0.
- Bubbles are not collapsed.
- s, cout and ovf are don't-care while out_valid=0.
REQ-025 If in_valid=1 while in_ready=0, the operands SHALL be ignored and not consumed; the producer holds them.
REQ-026 The carry into the MSB SHALL come from the last stage's chunk addition, giving ovf = c_msb XOR cout.
REQ-027 Wrap-around: a full-width carry ripple (e.g. all-ones + cin=1) SHALL resolve across the stages with no extra cycles.
REQ-028 With CHUNK=WIDTH, the block SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-029 On rst_n=0, all stage valid bits and out_valid SHALL clear to 0 immediately, without waiting for clk.
REQ-030 On rst_n=0, s, cout, ovf and all data and carry registers SHALL clear to 0.
REQ-031 On rst_n=0, in_ready SHALL be 1, because out_valid=0.
REQ-032 Reset mid-operation SHALL discard all in-flight results; the first edge after rst_n rises MAY accept input.

Structure
REQ-033 A shared package adder_pkg SHALL hold the default WIDTH and CHUNK constants.
REQ-034 adder_pkg SHALL hold a function computing STAGES and checking WIDTH % CHUNK == 0 at elaboration.
REQ-035 A combinational sub-module chunk_adder SHALL implement one stage's addition, parametrised by CHUNK.
- Inputs: x, y, ci.
- Outputs: sum, co, and the carry into its MSB.
- It SHALL be instantiated STAGES times by generate.
REQ-036 The top-level SHALL contain only registers, stall/valid logic and chunk_adder instances.

Verification
REQ-037 Ripple case, WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0000, cin=1, single shot -> out_valid after 4 edges; s=0x0000, cout=1, ovf=0.
REQ-038 Overflow case: a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000 -> s=0x0000, cout=1, ovf=1.
REQ-039 Streaming: 8 back-to-back operand sets (a=i, b=0x1000·i, cin=i&1), out_ready=1 -> 8 consecutive correct results, first after 4 edges, in order.
REQ-040 Stall: stream operands, drop out_ready for 3 cycles while full -> in_ready=0 during the stall; outputs stable; after release every result is seen exactly once, in order.
REQ-041 Reset: assert rst_n=0 with 3 results in flight -> out_valid=0 and s=0 with no clock edge; nothing from those results appears afterwards.
REQ-042 Exhaustive, WIDTH=4, CHUNK=1: all 512 combinations of a, b, cin, with random out_ready -> every s, cout and ovf matches the reference model.
